// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states and the
// sequential fetch increment.
package branch_predictor_pkg;

  localparam int unsigned CTR_W  = 2;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter; load wins over increment/decrement.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  input  logic load_i,
  input  ctr_e load_val_i,
  output ctr_e cnt_o
);

  ctr_e cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != ST)) begin
      cnt_d = ctr_e'(2'(cnt_q + 2'd1));
    end else if (dec_i && (cnt_q != SNT)) begin
      cnt_d = ctr_e'(2'(cnt_q - 2'd1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= WNT;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB predictor (bimodal or gshare) with a saturating
// mispredict statistics counter.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned GHR_W   = 0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] hist_x;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] cnt_msb;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;

  // Global history folds into the index only in gshare mode.
  if (GHR_W == 0) begin : g_bimodal
    assign hist_x = '0;
  end else begin : g_gshare
    logic [GHR_W-1:0] ghr_q, ghr_d;

    always_comb begin
      ghr_d = ghr_q;
      if (upd_valid) ghr_d = GHR_W'({ghr_q, upd_taken});
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) ghr_q <= '0;
      else       ghr_q <= ghr_d;
    end

    assign hist_x = IDX_W'(ghr_q);
  end

  assign f_idx = fetch_pc[IDX_W+1:2] ^ hist_x;
  assign u_idx = upd_pc[IDX_W+1:2] ^ hist_x;
  assign f_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Prediction reads only registered state, so same-cycle updates appear next cycle.
  assign pred_taken  = f_hit && cnt_msb[f_idx];
  assign pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + PC_W'(PC_INC);

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    ctr_e cnt_w;

    assign sel = upd_valid && (u_idx == IDX_W'(i));

    sat_counter2 u_ctr (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (sel && upd_taken && u_hit),
      .dec_i      (sel && !upd_taken),
      .load_i     (sel && upd_taken && !u_hit),
      .load_val_i (WT),
      .cnt_o      (cnt_w)
    );

    assign cnt_msb[i] = (cnt_w == WT) || (cnt_w == ST);
  end

  always_comb begin
    valid_d = valid_q;
    mcnt_d  = mcnt_q;
    if (upd_valid && upd_taken) valid_d[u_idx] = 1'b1;
    if (upd_valid && upd_mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      mcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Tag/target payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end
  end

  assign mispredict_count = mcnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of BHT/BTB entries; a power of two, at least 2.
REQ-002 Parameter PC_W, default 64, PC and target width.
REQ-003 Parameter TAG_W, default 8, BTB tag width.
REQ-004 Parameter GHR_W, default 0, global-history bits: 0 selects bimodal mode; 1..log2(ENTRIES) selects gshare mode.
REQ-005 Parameter CNT_W, default 32, width of the mispredict statistics counter.
REQ-006 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port fetch_pc  input  PC_W  PC of the instruction in IF.
REQ-009 Port pred_taken  output  1  predicted direction for fetch_pc.
REQ-010 Port pred_target  output  PC_W  next-fetch PC.
REQ-011 Port upd_valid  input  1  a resolved branch is presented this cycle.
REQ-012 Port upd_pc  input  PC_W  PC of the resolved branch.
REQ-013 Port upd_taken  input  1  actual branch direction.
REQ-014 Port upd_target  input  PC_W  actual branch target (the Adder-2 output carried in EX/MEM).
REQ-015 Port upd_mispredict  input  1  the pipeline flushed for this branch.
REQ-016 Port mispredict_count  output  CNT_W  number of mispredicts since reset.

Function
REQ-017 Let IDX_W = log2(ENTRIES).
REQ-018 The index SHALL be pc[IDX_W+1:2] XOR {zero-extension, ghr}; in bimodal mode the XOR term SHALL be 0.
REQ-019 The tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-020 Each entry SHALL hold: a 2-bit saturating counter, a BTB valid bit, a TAG_W tag and a PC_W target.
REQ-021 Prediction SHALL be combinational from registered state, with zero latency.
REQ-022 hit = valid AND (tag match).
REQ-023 pred_taken = hit AND counter[1].
REQ-024 pred_target = the stored target when pred_taken, else fetch_pc+4, computed modulo 2^PC_W.
REQ-025 On upd_valid, the counter at the update index SHALL increment if upd_taken and decrement otherwise, saturating at 3 and at 0.
REQ-026 On upd_valid with upd_taken, the BTB entry SHALL be written with valid=1, the tag of upd_pc and upd_target.
REQ-027 If an upd_taken update misses (invalid entry or tag mismatch), the counter SHALL be set to 2 (weakly taken) instead of incremented.
REQ-028 A not-taken update that misses SHALL leave valid, tag and target unchanged.
REQ-029 ghr SHALL be updated only on upd_valid: ghr <= {ghr[GHR_W-2:0], upd_taken}, i.e. non-speculative.
REQ-030 When fetch and update address the same index in the same cycle, the prediction SHALL use the pre-update state; the new state is visible the next cycle.
REQ-031 mispredict_count SHALL increment when upd_valid AND upd_mispredict, and saturate at all-ones (no wrap).
REQ-032 upd_mispredict without upd_valid SHALL be ignored.

Reset
REQ-033 While reset is high, all counters SHALL be 1 (weakly not-taken), all valid bits 0, ghr 0 and mispredict_count 0.
REQ-034 With all valid bits 0 during reset, pred_taken SHALL be 0 and pred_target SHALL be fetch_pc+4.
REQ-035 An update presented in the cycle reset deasserts SHALL be ignored only if reset is still high at the clock edge.
REQ-036 Tag and target storage need not be reset.

Structure
REQ-037 A shared package SHALL hold the counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the PC increment constant 4.
REQ-038 One sub-module, sat_counter2 (2-bit saturating counter with increment, decrement and load), SHALL be instantiated per entry.
REQ-039 Indexing, tag logic and the BTB array SHALL remain in branch_predictor.

Verification
REQ-040 Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-041 Update pc=0x100, taken, target=0x80 -> next cycle fetch 0x100 gives pred_taken=1, pred_target=0x80 (counter=2).
REQ-042 Two not-taken updates to 0x100 after REQ-041 -> counter 2->1->0, pred_taken=0; a third not-taken update keeps it at 0.
REQ-043 0x100 and 0x100+ENTRIES*4*2^TAG_W alias, tags equal -> second taken update overwrites the target; a differing-tag fetch misses.
REQ-044 Fetch and update on the same index in one cycle -> old prediction that cycle, new prediction the next cycle.
REQ-045 Set CNT_W=4 and apply 20 mispredicts -> mispredict_count=15; assert reset mid-sequence -> all state returns to reset values immediately.
